// File: rtl/video_types_pkg.sv
// rtl/video_types_pkg.sv - shared video constants, DMA state type and page fold helper
package video_types;

    localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
    localparam logic [15:0] OAM_LOC      = 16'hFE00;
    localparam int          OAM_SIZE     = 160;
    localparam logic [7:0]  ECHO_LO      = 8'hE0;
    localparam logic [7:0]  ECHO_HI      = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RD,
        WR
    } dma_state_t;

    // Echo RAM pages alias work RAM 0x2000 lower; widened compare keeps ECHO_HI=0xFF legal.
    function automatic logic [7:0] fold_page(input logic [7:0] page);
        if (({1'b0, page} >= {1'b0, ECHO_LO}) && ({1'b0, page} <= {1'b0, ECHO_HI}))
            return page - 8'h20;
        else
            return page;
    endfunction

endpackage

// File: rtl/dma_addr_gen.sv
// rtl/dma_addr_gen.sv - source page fold and source/destination address formation
module dma_addr_gen
    import video_types::*;
(
    input  logic [7:0]  page,
    input  logic [7:0]  idx,
    output logic [15:0] src_addr,
    output logic [15:0] dst_addr
);

    assign src_addr = {fold_page(page), idx};
    assign dst_addr = OAM_LOC + {8'h00, idx};

endmodule

// File: rtl/oam_dma_engine.sv
// rtl/oam_dma_engine.sv - OAM DMA bus initiator: copies one source page into OAM
module oam_dma_engine
    import video_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        reg_we,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic [7:0]  reg_rdata,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_re,
    output logic        bus_we,
    input  logic        bus_ack
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_SIZE - 1);

    dma_state_t state, state_next;
    logic [7:0] idx, idx_next;
    logic [7:0] page;
    logic [7:0] data_latch, latch_next;
    logic       done_next;
    logic       trigger;
    logic [15:0] src_addr, dst_addr;

    assign trigger = reg_we && (reg_addr == DMA_REG_ADDR);

    dma_addr_gen u_addr_gen (
        .page     (page),
        .idx      (idx),
        .src_addr (src_addr),
        .dst_addr (dst_addr)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= 8'h00;
            page       <= 8'h00;
            data_latch <= 8'h00;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            data_latch <= latch_next;
            done       <= done_next;
            if (trigger)
                page <= reg_wdata;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        latch_next = data_latch;
        done_next  = 1'b0;
        case (state)
            IDLE: ;
            REQ: begin
                if (bus_gnt)
                    state_next = RD;
            end
            RD: begin
                if (bus_ack) begin
                    latch_next = bus_rdata;
                    state_next = WR;
                end
            end
            WR: begin
                if (bus_ack) begin
                    if (idx == LAST_IDX) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 8'd1;
                        state_next = RD;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A new page write restarts from any state and swallows any pending done.
        if (trigger) begin
            state_next = REQ;
            idx_next   = 8'h00;
            done_next  = 1'b0;
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        bus_req   = (state != IDLE);
        bus_re    = (state == RD);
        bus_we    = (state == WR);
        bus_addr  = 16'h0000;
        bus_wdata = 8'h00;
        if (state == RD)
            bus_addr = src_addr;
        else if (state == WR) begin
            bus_addr  = dst_addr;
            bus_wdata = data_latch;
        end
    end

    assign reg_rdata = page;

endmodule
